// File: rtl/data_sram_responder_if.sv
// ---------------------------------------------------------------------------
// data_sram_responder_if
//   The miniCPU data-port bus. There is no handshake: every clock cycle
//   carries one request.
//
//   we     write strobe for the current cycle's request
//   addr   byte address; addr[1:0] is ignored by the responder
//   wdata  full-word write data
//   rdata  registered read data, valid one cycle after the address
//
//   modport master : CPU side (drives we/addr/wdata, receives rdata)
//   modport slave  : memory side (receives we/addr/wdata, drives rdata)
// ---------------------------------------------------------------------------
interface data_sram_responder_if;
   logic        we;
   logic [31:0] addr;
   logic [31:0] wdata;
   logic [31:0] rdata;

   modport master (
      output we,
      output addr,
      output wdata,
      input  rdata
   );

   modport slave (
      input  we,
      input  addr,
      input  wdata,
      output rdata
   );
endinterface

// File: rtl/data_sram_responder.sv
// ---------------------------------------------------------------------------
// data_sram_responder
//   Memory-side responder for the miniCPU data port. It holds a word-addressed
//   synchronous RAM and a small MMIO window (LED, switches, free-running
//   timer, result/done reporting).
//
//   Ports:
//     clk        system clock, all state on the rising edge
//     resetn     asynchronous active-low reset
//     data_sram  CPU data bus (slave side): we / addr / wdata / rdata
//     sw         board switches, asynchronous to clk
//     led        LED register
//     result     last value written to RESULT
//     done       sticky flag, set by the first RESULT write
//
//   Address map:
//     addr[31:16] == MMIO_HI  -> MMIO, decoded on addr[15:2]
//     anything else           -> RAM word addr[RAM_AW+1:2] (upper bits alias)
//
//   Reads are read-before-write: a write cycle returns the old contents of
//   the addressed location, and a read in the following cycle sees the new
//   value.
// ---------------------------------------------------------------------------
module data_sram_responder #(
   parameter int          RAM_AW  = 10,
   parameter logic [15:0] MMIO_HI = 16'hBFAF,
   parameter int          SW_W    = 16,
   parameter int          LED_W   = 16
) (
   input  logic                 clk,
   input  logic                 resetn,
   data_sram_responder_if.slave data_sram,
   input  logic [SW_W-1:0]      sw,
   output logic [LED_W-1:0]     led,
   output logic [31:0]          result,
   output logic                 done
);

   // ------------------------------------------------------------------
   // MMIO register map
   // ------------------------------------------------------------------
   localparam int NUM_REGS   = 5;
   localparam int LED_IX     = 0;
   localparam int SWITCH_IX  = 1;
   localparam int TIMER_IX   = 2;
   localparam int RESULT_IX  = 3;
   localparam int STATUS_IX  = 4;

   localparam logic [15:0] REG_OFS [NUM_REGS] = '{
      16'hF000,   // LED
      16'hF004,   // SWITCH
      16'hF008,   // TIMER
      16'hF00C,   // RESULT
      16'hF010    // STATUS
   };

   // ------------------------------------------------------------------
   // Request decode
   // ------------------------------------------------------------------
   logic                is_mmio;
   logic [13:0]         word_ofs;
   logic [NUM_REGS-1:0] reg_hit;
   logic [RAM_AW-1:0]   ram_idx;
   logic                ram_we;
   logic                wr_led;
   logic                wr_timer;
   logic                wr_result;

   // Byte lane bits carry no information on a word-only bus.
   logic unused_addr_bits;
   assign unused_addr_bits = ^data_sram.addr[1:0];

   assign is_mmio  = (data_sram.addr[31:16] == MMIO_HI);
   assign word_ofs = data_sram.addr[15:2];
   assign ram_idx  = data_sram.addr[RAM_AW+1:2];

   genvar gi;
   generate
      for (gi = 0; gi < NUM_REGS; gi++) begin : g_reg_hit
         assign reg_hit[gi] = is_mmio && (word_ofs == REG_OFS[gi][15:2]);
      end
   endgenerate

   // RAM writes are held off while reset is asserted so a reset sequence
   // never corrupts memory contents with whatever the bus happens to carry.
   assign ram_we    = data_sram.we && !is_mmio && resetn;
   assign wr_led    = data_sram.we && reg_hit[LED_IX];
   assign wr_timer  = data_sram.we && reg_hit[TIMER_IX];
   assign wr_result = data_sram.we && reg_hit[RESULT_IX];

   // ------------------------------------------------------------------
   // State
   // ------------------------------------------------------------------
   logic [LED_W-1:0] led_reg;
   logic [31:0]      result_reg;
   logic             done_reg;
   logic [31:0]      timer_reg;
   logic [31:0]      timer_next;
   logic [SW_W-1:0]  sw_meta_reg;
   logic [SW_W-1:0]  sw_sync_reg;
   logic [31:0]      mmio_rdata;
   logic [31:0]      mmio_rdata_reg;
   logic             sel_ram_reg;
   logic [31:0]      ram_rdata_reg;

   // A timer write replaces this edge's increment; counting resumes on the
   // next edge. Unsigned addition wraps 0xFFFFFFFF -> 0 naturally.
   always_comb begin
      timer_next = timer_reg + 32'd1;
      if (wr_timer) begin
         timer_next = data_sram.wdata;
      end
   end

   // MMIO read value, taken from the register state before this edge so a
   // write cycle returns the old contents. Unmapped offsets read zero.
   always_comb begin
      mmio_rdata = '0;
      if (reg_hit[LED_IX]) begin
         mmio_rdata = 32'(led_reg);
      end
      if (reg_hit[SWITCH_IX]) begin
         mmio_rdata = 32'(sw_sync_reg);
      end
      if (reg_hit[TIMER_IX]) begin
         mmio_rdata = timer_reg;
      end
      if (reg_hit[RESULT_IX]) begin
         mmio_rdata = result_reg;
      end
      if (reg_hit[STATUS_IX]) begin
         mmio_rdata = {31'd0, done_reg};
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         led_reg        <= '0;
         result_reg     <= '0;
         done_reg       <= 1'b0;
         timer_reg      <= '0;
         sw_meta_reg    <= '0;
         sw_sync_reg    <= '0;
         mmio_rdata_reg <= '0;
         sel_ram_reg    <= 1'b0;
      end else begin
         sw_meta_reg    <= sw;
         sw_sync_reg    <= sw_meta_reg;
         timer_reg      <= timer_next;
         mmio_rdata_reg <= mmio_rdata;
         sel_ram_reg    <= !is_mmio;
         if (wr_led) begin
            led_reg <= data_sram.wdata[LED_W-1:0];
         end
         if (wr_result) begin
            result_reg <= data_sram.wdata;
            done_reg   <= 1'b1;      // sticky until reset
         end
      end
   end

   // ------------------------------------------------------------------
   // Data RAM: read-first synchronous port, contents not reset. The read
   // register carries no reset so the array and its output register map
   // onto a block RAM; the async-reset select above masks it to zero.
   // ------------------------------------------------------------------
   logic [31:0] mem [2**RAM_AW];

   always_ff @(posedge clk) begin
      if (ram_we) begin
         mem[ram_idx] <= data_sram.wdata;
      end
      ram_rdata_reg <= mem[ram_idx];
   end

   // Both mux inputs are registers, so rdata is still a registered output;
   // while resetn is low sel_ram_reg and mmio_rdata_reg are both zero.
   assign data_sram.rdata = sel_ram_reg ? ram_rdata_reg : mmio_rdata_reg;

   assign led    = led_reg;
   assign result = result_reg;
   assign done   = done_reg;

endmodule

// File: doc/data_sram_responder.md
Name: data_sram_responder

Overview:
- Memory-side responder for the miniCPU data port. It receives the CPU's data_sram_we/addr/wdata and returns data_sram_rdata.
- Contains a word-addressed synchronous data RAM with one-cycle read latency and a small MMIO window: LED output, switch input, free-running timer, and a result/done register used to report the Fibonacci result.
- Sits beside minicpu_top in the SoC top level and connects directly to its data_sram_* pins.

Parameters:
- RAM_AW, 10, RAM word-address width; depth is 2^RAM_AW 32-bit words.
- MMIO_HI, 16'hBFAF, value of addr[31:16] that selects the MMIO window.
- SW_W, 16, switch input width.
- LED_W, 16, LED output width.

Ports:
- clk  input  1  system clock; all state on rising edge.
- resetn  input  1  asynchronous, active-low reset.
- data_sram_we  input  1  write strobe for the current cycle's request.
- data_sram_addr  input  32  byte address; addr[1:0] ignored.
- data_sram_wdata  input  32  write data.
- data_sram_rdata  output  32  read data, registered, valid one cycle after the address.
- sw  input  SW_W  asynchronous board switches.
- led  output  LED_W  LED register.
- result  output  32  last value written to RESULT.
- done  output  1  set by a write to RESULT.

Behaviour:
- Reset values: data_sram_rdata=0, led=0, result=0, done=0, timer=0, switch synchronizer flops=0. RAM contents are not reset.
- While resetn=0, rdata is forced to 0 asynchronously. Deassertion takes effect on the next rising edge.
- Address decode:
  - MMIO when addr[31:16]==MMIO_HI.
  - Otherwise RAM, indexed by addr[RAM_AW+1:2]. Upper RAM bits are ignored, so the RAM aliases.
- Every cycle is a request; there is no valid/handshake.
  - we=1: write on this edge.
  - Read: the address sampled at edge N produces rdata after edge N+1.
  - rdata holds until the next edge.
- Write cycle:
  - The addressed location is updated at the edge.
  - rdata after that edge shows the location's OLD value (read-before-write), for both RAM and MMIO.
- Back-to-back write then read of the same address: the read returns the new value.
- MMIO map (addr[15:0]):
  - 0xF000 LED: RW; writes load wdata[LED_W-1:0]; reads are zero-extended.
  - 0xF004 SWITCH: RO; 2-flop synchronized sw, zero-extended; writes ignored.
  - 0xF008 TIMER: RW; increments by 1 every cycle and wraps 0xFFFFFFFF→0. A write loads wdata and the increment resumes the following cycle. A read returns the value before that edge's increment.
  - 0xF00C RESULT: RW; a write loads result and sets done=1 the same edge; reads return result.
  - 0xF010 STATUS: RO; bit0=done, other bits 0; writes ignored.
  - Any other MMIO offset: reads 0, writes ignored, no side effects.
- done is sticky until reset. A second RESULT write updates result; done stays 1.
- No byte enables; all writes are full-word.
- Latency: read 1 cycle. Write takes effect at the sampling edge.

Test Plan:
- Reset: hold resetn=0 for 3 cycles with random inputs → rdata=0, led=0, result=0, done=0. Assert resetn=0 mid-run → rdata drops to 0 without waiting for a clock edge.
- RAM read/write:
  - Write 0x12345678 to 0x00000010, then read 0x10 → rdata=0x12345678 one cycle later.
  - Write 0xAAAA5555 to the same address, read in the following cycle → new value.
  - The write cycle's rdata shows the old value 0x12345678.
  - Aliasing: with RAM_AW=10, write 0x1 to 0x1010, read 0x0010 → 0x1.
- LED/switch:
  - Write 0xFFFF_BEEF to 0xBFAFF000 → led=0xBEEF; read gives 0x0000BEEF.
  - Set sw=0x00A5 → a read of 0xBFAFF004 issued two or more cycles later returns 0x000000A5.
  - Write to 0xBFAFF004 → no effect.
- Timer:
  - Write 0xFFFFFFFE to 0xBFAFF008, then read the timer on each of the next 3 cycles → 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000 (wraparound).
- Result/done:
  - Read 0xBFAFF010 → 0.
  - Write 55 (0x37) to 0xBFAFF00C → result=0x37, done=1 the same edge; STATUS read → 0x1.
  - Write 89 → result=0x59, done stays 1.
- Unmapped:
  - Read 0xBFAFF020 → 0.
  - Write 0xDEAD to 0xBFAFF020 → led, result, and timer are unaffected.
